// File: rtl/negator_result_collector.sv
// negator_result_collector: buffers negator results in a small FIFO and drains them to a stallable memory write port, one job at a time.
// Latency: a word accepted at cycle t is written at t+1 at the earliest; there is no combinational in->mem path.
// Backpressure: in_ready drops when the FIFO is full or the job count is reached; mem_busy stalls the drain. COLLECTOR_CHECKSUM_EN adds a checksum port.
module negator_result_collector #(
  parameter int DATA_WIDTH  = 64,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] word_count,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   mem_busy,
  output logic                   mem_wr_en,
  output logic [ADDR_WIDTH-1:0]  mem_wr_addr,
  output logic [DATA_WIDTH-1:0]  mem_wr_data,
  output logic                   busy,
  output logic                   done
`ifdef COLLECTOR_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]  checksum
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [COUNT_WIDTH-1:0] job_cnt;
  logic [COUNT_WIDTH-1:0] rx_cnt;
  logic [COUNT_WIDTH-1:0] wr_cnt;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W:0]         occ;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   start_ok;
  logic                   push;
  logic                   pop;

  assign fifo_full  = (occ == FULL_OCC);
  assign fifo_empty = (occ == '0);
  // A start pulse while a job is running is dropped on the floor.
  assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
  assign push       = in_valid && in_ready;
  assign pop        = mem_wr_en;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: transitions look at registered counters only.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_nxt = (word_count == '0) ? S_DONE : S_COLLECT;
      S_COLLECT:      if (rx_cnt == job_cnt) state_nxt = S_DRAIN;
      S_DRAIN:        if (wr_cnt == job_cnt) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Outputs: in_ready is a function of registered state only (no full-bypass).
  always_comb begin
    in_ready    = (state == S_COLLECT) && !fifo_full && (rx_cnt < job_cnt);
    mem_wr_en   = !fifo_empty && !mem_busy && ((state == S_COLLECT) || (state == S_DRAIN));
    mem_wr_addr = base_q + ADDR_WIDTH'(wr_cnt);
    mem_wr_data = fifo_mem[rd_ptr];
    busy        = (state == S_COLLECT) || (state == S_DRAIN);
    done        = (state == S_DONE);
  end

  // Job registers, counters and FIFO storage; reset discards any buffered words.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      job_cnt <= '0;
      base_q  <= '0;
      rx_cnt  <= '0;
      wr_cnt  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (start_ok) begin
      job_cnt <= word_count;
      base_q  <= base_addr;
      rx_cnt  <= '0;
      wr_cnt  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= in_data;
        wr_ptr           <= wr_ptr + PTR_W'(1);
        rx_cnt           <= rx_cnt + COUNT_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        wr_cnt <= wr_cnt + COUNT_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

`ifdef COLLECTOR_CHECKSUM_EN
  // Running XOR of every word written in the current job.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        checksum <= '0;
    else if (start_ok) checksum <= '0;
    else if (pop)      checksum <= checksum ^ mem_wr_data;
  end
`endif

endmodule

// File: tb/tb_negator_result_collector.sv
// tb_negator_result_collector: directed and random jobs against a queue-based model of the collector.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
// Optional checksum port is compared when COLLECTOR_CHECKSUM_EN is defined.
module tb_negator_result_collector;
  localparam int DW = 64;
  localparam int DEPTH = 4;
  localparam int AW = 32;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          start = 1'b0;
  logic [CW-1:0] word_count = '0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          mem_busy = 1'b0;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          busy;
  logic          done;
`ifdef COLLECTOR_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  negator_result_collector #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .word_count(word_count), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .mem_busy(mem_busy),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .done(done)
`ifdef COLLECTOR_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  initial forever #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_acc = -1;
  int first_wr = -1;
  int done_cyc = -1;
  int ready_cyc = 0;
  logic [AW-1:0] log_a[$];
  logic [DW-1:0] log_d[$];
  int            log_c[$];
  bit busy_rand = 1'b0;
  bit busy_force = 1'b0;
  int busy_pct = 0;
  logic [DW-1:0] wbuf [16];

  // Model: phase 0 idle, 1 collecting, 2 draining, 3 done; the FIFO is a queue.
  int            m_phase = 0;
  logic [DW-1:0] m_q[$];
  int            m_rx = 0;
  int            m_wr = 0;
  int            m_cnt = 0;
  logic [AW-1:0] m_base = '0;
  logic [DW-1:0] m_sum = '0;

  function automatic bit m_ready();
    return (m_phase == 1) && (m_q.size() < DEPTH) && (m_rx < m_cnt);
  endfunction

  function automatic bit m_wen();
    return (m_q.size() > 0) && !mem_busy && (m_phase == 1 || m_phase == 2);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", nm, $time, act, exp);
    end
  endtask

  // Model update on each rising edge, or immediately on reset assertion.
  initial begin : model
    bit mp_push, mp_pop;
    int mp_next;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_phase = 0; m_q.delete(); m_rx = 0; m_wr = 0; m_cnt = 0; m_base = '0; m_sum = '0;
      end else begin
        mp_push = in_valid && m_ready();
        mp_pop  = m_wen();
        if (m_phase == 0 || m_phase == 3) begin
          if (start) begin
            m_cnt = int'(word_count); m_base = base_addr; m_rx = 0; m_wr = 0; m_sum = '0;
            m_q.delete();
            m_phase = (word_count == 0) ? 3 : 1;
          end
        end else begin
          mp_next = m_phase;
          if (m_phase == 1 && m_rx == m_cnt) mp_next = 2;
          if (m_phase == 2 && m_wr == m_cnt) mp_next = 3;
          if (mp_pop) begin m_sum = m_sum ^ m_q[0]; void'(m_q.pop_front()); m_wr++; end
          if (mp_push) begin m_q.push_back(in_data); m_rx++; end
          m_phase = mp_next;
        end
      end
    end
  end

  // Compare every falling edge and log DUT activity for the directed checks.
  initial begin : compare
    logic [AW-1:0] exp_addr;
    forever begin
      @(negedge clock);
      cyc++;
      exp_addr = m_base + AW'(m_wr);
      chk("in_ready", 64'(in_ready), 64'(m_ready()));
      chk("mem_wr_en", 64'(mem_wr_en), 64'(m_wen()));
      chk("busy", 64'(busy), 64'(m_phase == 1 || m_phase == 2));
      chk("done", 64'(done), 64'(m_phase == 3));
      chk("mem_wr_addr", 64'(mem_wr_addr), 64'(exp_addr));
      if (m_wen()) chk("mem_wr_data", mem_wr_data, m_q[0]);
`ifdef COLLECTOR_CHECKSUM_EN
      chk("checksum", checksum, m_sum);
`endif
      if (in_valid && in_ready && first_acc < 0) first_acc = cyc;
      if (in_ready) ready_cyc++;
      if (mem_wr_en) begin
        log_a.push_back(mem_wr_addr); log_d.push_back(mem_wr_data); log_c.push_back(cyc);
        if (first_wr < 0) first_wr = cyc;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
    end
  end

  // Memory stall driver: forced level or random.
  initial forever begin
    @(posedge clock); #1;
    mem_busy = busy_rand ? (int'($urandom_range(0, 99)) < busy_pct) : busy_force;
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic do_start(input int cnt, input logic [AW-1:0] ba);
    start = 1'b1; word_count = CW'(cnt); base_addr = ba;
    step();
    start = 1'b0;
    first_acc = -1; first_wr = -1; done_cyc = -1; ready_cyc = 0;
  endtask

  task automatic send_words(input int first, input int n, input int patience, input int gap_pct,
                            input bit expect_stall, output int sent);
    int waited;
    bit acc;
    sent = 0; waited = 0;
    while (sent < n && waited < patience) begin
      in_valid = 1'b1; in_data = wbuf[first + sent];
      @(negedge clock); acc = in_ready;
      step();
      if (acc) begin
        sent++; waited = 0;
        if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
          in_valid = 1'b0;
          repeat ($urandom_range(1, 3)) step();
        end
      end else waited++;
    end
    if (sent == n) in_valid = 1'b0;
    if (sent < n && !expect_stall) begin
      checks++; errors++;
      $display("FAIL send_timeout sent=%0d required=%0d", sent, n);
    end
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (k < budget) begin
      @(negedge clock);
      if (done) break;
      k++;
    end
    step();
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL wait_done actual=timeout required=done_within_%0d", budget);
    end
  endtask

  task automatic chk_log(input int lb, input int n, input logic [AW-1:0] ba);
    logic [AW-1:0] ea;
    chk("log_count", 64'(log_a.size() - lb), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (lb + i < log_a.size()) begin
        ea = ba + AW'(i);
        chk("log_addr", 64'(log_a[lb + i]), 64'(ea));
        chk("log_data", log_d[lb + i], wbuf[i]);
      end
    end
  endtask

  initial begin : watchdog
    #400000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lb, sent, s2, n;
    logic [AW-1:0] ba;
    reset = 1'b1;
    #2 reset = 1'b0;
    in_valid = 1'b1; in_data = 64'hDEAD_BEEF;

    // 1: reset held with in_valid high
    repeat (3) @(negedge clock);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_addr", 64'(mem_wr_addr), 64'd0);
    chk("rst_data", mem_wr_data, 64'd0);
    step();
    in_valid = 1'b0; reset = 1'b1;
    step();

    // 2: four words back-to-back, no stall
    for (int i = 0; i < 4; i++) wbuf[i] = DW'(i + 1);
    lb = log_a.size();
    do_start(4, 32'h100);
    send_words(0, 4, 50, 0, 1'b0, sent);
    wait_done(100);
    chk_log(lb, 4, 32'h100);
    chk("t2_first_latency", 64'(first_wr - first_acc), 64'd1);
    if (log_a.size() >= lb + 4) begin
      for (int i = 1; i < 4; i++) chk("t2_consecutive", 64'(log_c[lb + i] - log_c[lb + i - 1]), 64'd1);
      chk("t2_done_after_last", 64'(done_cyc > log_c[lb + 3]), 64'd1);
    end

    // 3: eight words with memory stalled; FIFO fills at four
    for (int i = 0; i < 8; i++) wbuf[i] = 64'hA5A5_0000_0000_0000 | DW'(i);
    busy_force = 1'b1;
    step(); step();
    lb = log_a.size();
    do_start(8, 32'h1000);
    send_words(0, 8, 8, 0, 1'b1, sent);
    chk("t3_stall_accepts", 64'(sent), 64'd4);
    chk("t3_ready_low", 64'(in_ready), 64'd0);
    busy_force = 1'b0;
    send_words(sent, 8 - sent, 100, 0, 1'b0, s2);
    wait_done(200);
    chk_log(lb, 8, 32'h1000);

    // 4: zero-length job
    lb = log_a.size();
    do_start(0, 32'h2000);
    @(negedge clock);
    chk("t4_done_next", 64'(done), 64'd1);
    step();
    repeat (3) step();
    chk("t4_never_ready", 64'(ready_cyc), 64'd0);
    chk("t4_no_writes", 64'(log_a.size() - lb), 64'd0);

    // 5: address wrap
    for (int i = 0; i < 3; i++) wbuf[i] = {$urandom, $urandom};
    lb = log_a.size();
    do_start(3, 32'hFFFF_FFFE);
    send_words(0, 3, 50, 0, 1'b0, sent);
    wait_done(100);
    chk_log(lb, 3, 32'hFFFF_FFFE);
    if (log_a.size() >= lb + 3) chk("t5_wrap_addr", 64'(log_a[lb + 2]), 64'd0);

    // 6: reset mid-job, then a clean two-word job
    busy_force = 1'b1;
    step(); step();
    for (int i = 0; i < 5; i++) wbuf[i] = DW'(32'h5000 + i);
    do_start(5, 32'h3000);
    send_words(0, 2, 20, 0, 1'b0, sent);
    reset = 1'b0;
    @(negedge clock);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_ready", 64'(in_ready), 64'd0);
    chk("t6_rst_wr_en", 64'(mem_wr_en), 64'd0);
    step();
    reset = 1'b1; busy_force = 1'b0;
    step(); step();
    chk("t6_idle_no_write", 64'(mem_wr_en), 64'd0);
    wbuf[0] = 64'hF0; wbuf[1] = 64'h0F;
    lb = log_a.size();
    do_start(2, 32'h3000);
    send_words(0, 2, 50, 0, 1'b0, sent);
    wait_done(100);
    chk_log(lb, 2, 32'h3000);
`ifdef COLLECTOR_CHECKSUM_EN
    chk("t6_checksum", checksum, 64'hFF);
`endif

    // Random jobs with random stalls and upstream gaps
    busy_rand = 1'b1;
    for (int j = 0; j < 8; j++) begin
      n = int'($urandom_range(1, 12));
      ba = $urandom;
      for (int i = 0; i < n; i++) wbuf[i] = {$urandom, $urandom};
      busy_pct = int'($urandom_range(0, 60));
      lb = log_a.size();
      do_start(n, ba);
      send_words(0, n, 500, 30, 1'b0, sent);
      wait_done(2000);
      chk_log(lb, n, ba);
    end
    busy_rand = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
